// File: rtl/seg7_scan_ctrl.sv
// Multi-digit 7-segment scan controller: holds DIGITS hex entries, time-multiplexes them onto a shared
// segment bus with a one-cycle blanking gap per slot, per-digit blank/blink and registered readback.
module seg7_scan_ctrl #(
  parameter int DIGITS      = 4,
  parameter int CNT_DIV     = 50000,
  parameter int BLINK_TICKS = 250,
  parameter int ACTIVE_LOW  = 1,
  localparam int AW         = $clog2(DIGITS)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WE,
  input  logic [AW-1:0]     WADDR,
  input  logic [4:0]        WDATA,
  input  logic [DIGITS-1:0] BLINK_EN,
  output logic [4:0]        RDATA,
  output logic [6:0]        SEG,
  output logic [DIGITS-1:0] DIG_SEL
);

  localparam int PW = (CNT_DIV > 1) ? $clog2(CNT_DIV) : 1;
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [PW-1:0]     PRESC_MAX = PW'(CNT_DIV - 1);
  localparam logic [BW-1:0]     BLINK_MAX = BW'(BLINK_TICKS - 1);
  localparam logic [AW-1:0]     SCAN_MAX  = AW'(DIGITS - 1);
  localparam bit                INV       = (ACTIVE_LOW != 0);
  localparam logic [6:0]        SEG_OFF   = INV ? 7'h7F : 7'h00;
  localparam logic [DIGITS-1:0] DIG_OFF   = INV ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [PW-1:0]     presc;
  logic              tick;
  logic [AW-1:0]     scan_idx;
  logic [BW-1:0]     blink_cnt;
  logic              blink_phase;
  logic [4:0]        entry [DIGITS];
  logic [4:0]        cur;
  logic              cur_blink;
  logic [DIGITS-1:0] sel_hot;
  logic [6:0]        seg_on;
  logic [6:0]        seg_d;
  logic [DIGITS-1:0] dig_d;
  logic [4:0]        rdata_d;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    case (v)
      4'h0: hex_to_seg = 7'h3F;
      4'h1: hex_to_seg = 7'h06;
      4'h2: hex_to_seg = 7'h5B;
      4'h3: hex_to_seg = 7'h4F;
      4'h4: hex_to_seg = 7'h66;
      4'h5: hex_to_seg = 7'h6D;
      4'h6: hex_to_seg = 7'h7D;
      4'h7: hex_to_seg = 7'h07;
      4'h8: hex_to_seg = 7'h7F;
      4'h9: hex_to_seg = 7'h6F;
      4'hA: hex_to_seg = 7'h77;
      4'hB: hex_to_seg = 7'h7C;
      4'hC: hex_to_seg = 7'h39;
      4'hD: hex_to_seg = 7'h5E;
      4'hE: hex_to_seg = 7'h79;
      default: hex_to_seg = 7'h71;
    endcase
  endfunction

  assign tick = (presc == PRESC_MAX);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      presc       <= '0;
      scan_idx    <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      if (tick) begin
        scan_idx <= (scan_idx == SCAN_MAX) ? '0 : scan_idx + AW'(1);
        if (blink_cnt == BLINK_MAX) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + BW'(1);
        end
      end
    end
  end

  // WE is a single-cycle strobe with no back-pressure; an address past the last digit matches no entry.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DIGITS; i++) entry[i] <= 5'h10;
    end else begin
      for (int i = 0; i < DIGITS; i++)
        if (WE && (WADDR == AW'(i))) entry[i] <= WDATA;
    end
  end

  always_comb begin
    cur       = 5'h10;
    cur_blink = 1'b0;
    sel_hot   = '0;
    rdata_d   = 5'h10;
    for (int i = 0; i < DIGITS; i++) begin
      if (scan_idx == AW'(i)) begin
        cur        = entry[i];
        cur_blink  = BLINK_EN[i];
        sel_hot[i] = 1'b1;
      end
      if (WADDR == AW'(i)) rdata_d = entry[i];
    end
    seg_on = hex_to_seg(cur[3:0]);
    seg_d  = SEG_OFF;
    dig_d  = DIG_OFF;
    // The tick cycle drives everything dark so the previous digit never ghosts onto the next one.
    if (!tick) begin
      dig_d = INV ? ~sel_hot : sel_hot;
      if (!cur[4] && !(cur_blink && blink_phase)) seg_d = INV ? ~seg_on : seg_on;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      SEG     <= SEG_OFF;
      DIG_SEL <= DIG_OFF;
      RDATA   <= 5'h10;
    end else begin
      SEG     <= seg_d;
      DIG_SEL <= dig_d;
      RDATA   <= rdata_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl (DIGITS=4, CNT_DIV=4, BLINK_TICKS=2, ACTIVE_LOW=1) plus a
// DIGITS=3 instance for out-of-range write addresses.
module tb_seg7_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       we;
  logic [1:0] waddr;
  logic [4:0] wdata;
  logic [3:0] blink_en;
  logic [4:0] rdata;
  logic [6:0] seg;
  logic [3:0] dig_sel;

  logic       we3;
  logic [1:0] waddr3;
  logic [4:0] wdata3;
  logic [4:0] rdata3;
  logic [6:0] seg3;
  logic [2:0] dig_sel3;

  int n_checks = 0;
  int n_fail   = 0;
  int n        = 0;  // edges since reset release

  logic [3:0] exp_idle_sel [16] = '{4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD, 4'hF,
                                    4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7, 4'hF};
  logic [3:0] exp_sel [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
  logic [6:0] exp_seg_1234 [4] = '{7'h79, 7'h24, 7'h30, 7'h19};

  always #5 clk = ~clk;

  seg7_scan_ctrl #(.DIGITS(4), .CNT_DIV(4), .BLINK_TICKS(2), .ACTIVE_LOW(1)) u_dut (
    .CLK(clk), .RST(rst), .WE(we), .WADDR(waddr), .WDATA(wdata), .BLINK_EN(blink_en),
    .RDATA(rdata), .SEG(seg), .DIG_SEL(dig_sel)
  );

  seg7_scan_ctrl #(.DIGITS(3), .CNT_DIV(4), .BLINK_TICKS(2), .ACTIVE_LOW(1)) u_dut3 (
    .CLK(clk), .RST(rst), .WE(we3), .WADDR(waddr3), .WDATA(wdata3), .BLINK_EN(3'b000),
    .RDATA(rdata3), .SEG(seg3), .DIG_SEL(dig_sel3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, n);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    n++;
  endtask

  // Advance to the first lit cycle of digit d; the position comes from the edge count alone.
  task automatic seek(input int d);
    bit found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      if (((n - 1) % 4 == 0) && (((n - 1) / 4) % 4 == d)) found = 1'b1;
    end
    if (!found) begin
      n_fail++;
      $display("FAIL seek: digit %0d not reached within 20 edges", d);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [4:0] d);
    we = 1'b1; waddr = a; wdata = d;
    step();
    we = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; blink_en = '0;
    we3 = 1'b0; waddr3 = '0; wdata3 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_seg", seg, 7'h7F);
    check("reset_dig", dig_sel, 4'hF);
    check("reset_rdata", rdata, 5'h10);
    check("reset_rdata3", rdata3, 5'h10);
    @(negedge clk);
    rst = 1'b0;
    n = 0;

    // Idle scan: blank digits, one gap cycle per slot.
    for (int i = 0; i < 16; i++) begin
      step();
      check("idle_seg", seg, 7'h7F);
      check("idle_dig", dig_sel, exp_idle_sel[i]);
    end

    // Digits 1,2,3,4.
    for (int i = 0; i < 4; i++) wr(2'(i), 5'(i + 1));
    for (int i = 0; i < 4; i++) begin
      seek(i);
      check("val_seg", seg, exp_seg_1234[i]);
      check("val_dig", dig_sel, exp_sel[i]);
    end
    waddr = 2'd2;
    step();
    check("rdata_d2", rdata, 5'h03);

    // Blank bit on d2; d3 unaffected.
    wr(2'd2, 5'h1A);
    seek(2);
    check("blank_seg", seg, 7'h7F);
    check("blank_dig", dig_sel, 4'hB);
    check("blank_rdata", rdata, 5'h1A);
    seek(3);
    check("after_blank_d3", seg, 7'h19);

    // Out-of-range write on the 3-digit build is dropped; an in-range one lands.
    we3 = 1'b1; waddr3 = 2'd3; wdata3 = 5'h05;
    step();
    we3 = 1'b0;
    for (int a = 0; a < 4; a++) begin
      waddr3 = 2'(a);
      step();
      check("bad_addr_rdata3", rdata3, 5'h10);
    end
    we3 = 1'b1; waddr3 = 2'd1; wdata3 = 5'h07;
    step();
    we3 = 1'b0;
    step();
    check("good_addr_rdata3", rdata3, 5'h07);

    // Blink: d0 slots always fall in phase 0, d2 slots in phase 1 for this build.
    wr(2'd0, 5'h08);
    wr(2'd2, 5'h08);
    blink_en = 4'b0101;
    seek(0);
    check("blink_d0_phase0", seg, 7'h00);
    seek(1);
    check("blink_d1_unaffected", seg, 7'h24);
    seek(2);
    check("blink_d2_phase1_seg", seg, 7'h7F);
    check("blink_d2_phase1_dig", dig_sel, 4'hB);
    blink_en = 4'b0000;
    seek(2);
    check("noblink_d2", seg, 7'h00);

    // Write d1 while it is lit: old value for one more edge, then new.
    seek(1);
    check("live_before", seg, 7'h24);
    we = 1'b1; waddr = 2'd1; wdata = 5'h05;
    step();
    we = 1'b0;
    check("live_edge1_seg", seg, 7'h24);
    check("live_edge1_rdata", rdata, 5'h02);
    step();
    check("live_edge2_seg", seg, 7'h12);
    check("live_edge2_rdata", rdata, 5'h05);

    // Async reset mid-slot on d2.
    seek(2);
    step();
    check("pre_rst_seg", seg, 7'h00);
    #2 rst = 1'b1;
    #1;
    check("async_rst_seg", seg, 7'h7F);
    check("async_rst_dig", dig_sel, 4'hF);
    check("async_rst_rdata", rdata, 5'h10);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    step();
    check("restart_dig", dig_sel, 4'hE);
    check("restart_seg", seg, 7'h7F);
    for (int a = 0; a < 4; a++) begin
      waddr = 2'(a);
      step();
      check("restart_rdata", rdata, 5'h10);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
